// File: rtl/descramble_pdu_if.sv
// Bit-stream bus between the access-address correlator, the de-whitener and the CRC checker.
// master drives whitened bits and channel selection; slave returns de-whitened bits and framing.
interface descramble_pdu_if #(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6
) ();
    logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number;
    logic                                channel_number_load;
    logic                                data_in;
    logic                                data_in_valid;
    logic                                data_in_valid_first;
    logic                                data_out;
    logic                                data_out_valid;
    logic                                data_out_valid_last;
    logic [7:0]                          payload_length;
    logic                                payload_length_valid;
    logic                                length_error;

    modport master (
        output channel_number, channel_number_load, data_in, data_in_valid, data_in_valid_first,
        input  data_out, data_out_valid, data_out_valid_last,
        input  payload_length, payload_length_valid, length_error
    );

    modport slave (
        input  channel_number, channel_number_load, data_in, data_in_valid, data_in_valid_first,
        output data_out, data_out_valid, data_out_valid_last,
        output payload_length, payload_length_valid, length_error
    );
endinterface

// File: rtl/descramble_pdu.sv
// BTLE receive de-whitening (x^7+x^4+1, channel seeded) and PDU framing:
// recovers the header length field and flags the final CRC bit for the CRC checker.
module descramble_pdu #(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int MAX_PDU_LENGTH           = 255
) (
    input  logic            clk,
    input  logic            rst,
    descramble_pdu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CRC} state_t;

    localparam logic [8:0] MAX_LEN = 9'(MAX_PDU_LENGTH);

    state_t                              state_reg, state_next;
    logic [11:0]                         cnt_reg, cnt_next;
    logic [11:0]                         target_reg, target_next;
    logic [6:0]                          lfsr_reg, lfsr_next;
    logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] seed_reg, seed_next;
    logic [7:0]                          len_sr_reg, len_sr_next;
    logic [7:0]                          plen_reg, plen_next;
    logic                                dout_reg, dout_next;
    logic                                dvalid_reg, dvalid_next;
    logic                                last_reg, last_next;
    logic                                plv_reg, plv_next;
    logic                                lerr_reg, lerr_next;

    logic       start, accept, dbit;
    logic [6:0] seeded, cur, shifted;
    logic [7:0] new_len;

    // Fresh LFSR state for a PDU start: p0 = 1, p1..p6 = seed MSB..LSB.
    assign seeded[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_seed
            assign seeded[gi+1] = seed_reg[5-gi];
        end
    endgenerate

    assign start   = bus.data_in_valid & bus.data_in_valid_first;
    assign accept  = bus.data_in_valid & (start | (state_reg != IDLE));
    assign cur     = start ? seeded : lfsr_reg;
    assign dbit    = bus.data_in ^ cur[6];
    assign new_len = {dbit, len_sr_reg[7:1]};
    assign shifted = {cur[5], cur[4], cur[3] ^ cur[6], cur[2], cur[1], cur[0], cur[6]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            target_reg <= '0;
            lfsr_reg   <= '0;
            seed_reg   <= '0;
            len_sr_reg <= '0;
            plen_reg   <= '0;
            dout_reg   <= 1'b0;
            dvalid_reg <= 1'b0;
            last_reg   <= 1'b0;
            plv_reg    <= 1'b0;
            lerr_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            target_reg <= target_next;
            lfsr_reg   <= lfsr_next;
            seed_reg   <= seed_next;
            len_sr_reg <= len_sr_next;
            plen_reg   <= plen_next;
            dout_reg   <= dout_next;
            dvalid_reg <= dvalid_next;
            last_reg   <= last_next;
            plv_reg    <= plv_next;
            lerr_reg   <= lerr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        target_next = target_reg;
        lfsr_next   = lfsr_reg;
        len_sr_next = len_sr_reg;
        plen_next   = plen_reg;
        // A load coinciding with a start still lets that start use the old seed_reg.
        seed_next   = bus.channel_number_load ? bus.channel_number : seed_reg;
        dout_next   = 1'b0;
        dvalid_next = 1'b0;
        last_next   = 1'b0;
        plv_next    = 1'b0;
        lerr_next   = 1'b0;

        if (accept) begin
            lfsr_next   = shifted;
            dout_next   = dbit;
            dvalid_next = 1'b1;
            if (start) begin
                // Also the abort path: a first bit mid-PDU silently restarts framing.
                state_next  = HEADER;
                cnt_next    = 12'd1;
                len_sr_next = '0;
            end else begin
                case (state_reg)
                    HEADER: begin
                        cnt_next = cnt_reg + 12'd1;
                        if (cnt_reg >= 12'd8) len_sr_next = new_len;
                        if (cnt_reg == 12'd15) begin
                            plen_next = new_len;
                            plv_next  = 1'b1;
                            cnt_next  = '0;
                            if ({1'b0, new_len} > MAX_LEN) begin
                                lerr_next  = 1'b1;
                                last_next  = 1'b1;
                                state_next = IDLE;
                            end else if (new_len == 8'd0) begin
                                state_next = CRC;
                            end else begin
                                target_next = {1'b0, new_len, 3'b000};
                                state_next  = PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (cnt_reg + 12'd1 == target_reg) begin
                            cnt_next   = '0;
                            state_next = CRC;
                        end else begin
                            cnt_next = cnt_reg + 12'd1;
                        end
                    end
                    CRC: begin
                        if (cnt_reg == 12'd23) begin
                            last_next  = 1'b1;
                            cnt_next   = '0;
                            state_next = IDLE;
                        end else begin
                            cnt_next = cnt_reg + 12'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.data_out             = dout_reg;
    assign bus.data_out_valid       = dvalid_reg;
    assign bus.data_out_valid_last  = last_reg;
    assign bus.payload_length       = plen_reg;
    assign bus.payload_length_valid = plv_reg;
    assign bus.length_error         = lerr_reg;
endmodule

// File: tb/tb_descramble_pdu.sv
// Scoreboard bench for descramble_pdu: the driver queues expected de-whitened bits and
// framing flags, an independent monitor pops and compares each output bit.
module tb_descramble_pdu;
    localparam int MAXLEN = 37;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    descramble_pdu_if #(.CHANNEL_NUMBER_BIT_WIDTH(6)) bus ();

    descramble_pdu #(
        .CHANNEL_NUMBER_BIT_WIDTH(6),
        .MAX_PDU_LENGTH(MAXLEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic       d;
        logic       last;
        logic       plv;
        logic       lerr;
        logic [7:0] plen;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks_total = 0;
    int   checks_passed = 0;
    int   out_count = 0;
    int   last_count = 0;
    logic [6:0] mp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks_total++;
        if (act === req) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Monitor: every presented output bit is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.data_out_valid === 1'b1) begin
            out_count++;
            if (bus.data_out_valid_last === 1'b1) last_count++;
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                $display("out %0d: d=%0b last=%0b plv=%0b lerr=%0b plen=%0d", out_count,
                         bus.data_out, bus.data_out_valid_last, bus.payload_length_valid,
                         bus.length_error, bus.payload_length);
                chk("data_out", 32'(bus.data_out), 32'(mon_e.d));
                chk("data_out_valid_last", 32'(bus.data_out_valid_last), 32'(mon_e.last));
                chk("payload_length_valid", 32'(bus.payload_length_valid), 32'(mon_e.plv));
                chk("length_error", 32'(bus.length_error), 32'(mon_e.lerr));
                if (mon_e.plv) chk("payload_length", 32'(bus.payload_length), 32'(mon_e.plen));
            end
        end
    end

    // Reference whitening LFSR: p0..p6 held in mp[0..6].
    function automatic void m_seed(input logic [5:0] s);
        mp[0] = 1'b1;
        for (int i = 0; i < 6; i++) mp[1+i] = s[5-i];
    endfunction

    function automatic logic m_step();
        logic w;
        w  = mp[6];
        mp = {mp[5], mp[4], mp[3] ^ mp[6], mp[2], mp[1], mp[0], mp[6]};
        return w;
    endfunction

    function automatic logic plain_bit(input int i, input logic [7:0] h0, input logic [7:0] ln);
        logic [31:0] v;
        if (i < 8) return h0[3'(i)];
        if (i < 16) return ln[3'(i - 8)];
        v = 32'(i) * 32'd37 + 32'd11;
        return v[3] ^ v[0];
    endfunction

    // Called at a negedge; returns at a negedge after the bit and its gap.
    task automatic send_bit(input logic din, input logic first, input logic valid, input logic load,
                            input logic [5:0] ch, input logic exp_out, input exp_t e, input int gap);
        if (exp_out) sb.push_back(e);
        bus.data_in             = din;
        bus.data_in_valid       = valid;
        bus.data_in_valid_first = first;
        bus.channel_number_load = load;
        bus.channel_number      = ch;
        @(negedge clk);
        chk("valid_latency", 32'(bus.data_out_valid), 32'(exp_out));
        bus.data_in_valid       = 1'b0;
        bus.data_in_valid_first = 1'b0;
        bus.channel_number_load = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_pdu(input logic [5:0] seed, input logic [7:0] h0, input logic [7:0] len,
                           input int stop_at, input int load_at, input logic [5:0] load_ch);
        int   total, n;
        logic err, pb, w;
        exp_t e;
        err   = (int'(len) > MAXLEN);
        total = err ? 16 : 16 + 8 * int'(len) + 24;
        n     = (stop_at > 0) ? stop_at : total;
        out_count  = 0;
        last_count = 0;
        m_seed(seed);
        for (int i = 0; i < n; i++) begin
            pb     = plain_bit(i, h0, len);
            w      = m_step();
            e.d    = pb;
            e.last = (i == total - 1);
            e.plv  = (i == 15);
            e.lerr = err && (i == 15);
            e.plen = len;
            send_bit(pb ^ w, i == 0, 1'b1, i == load_at, load_ch, 1'b1, e, 0);
        end
        repeat (2) @(negedge clk);
        chk("pdu_output_count", 32'(out_count), 32'(n));
        chk("pdu_last_count", 32'(last_count), (stop_at > 0) ? 32'd0 : 32'd1);
    endtask

    task automatic send_ignored(input int n);
        for (int i = 0; i < n; i++) send_bit(1'(i & 1), 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, '0, 0);
    endtask

    localparam logic [7:0] CH37_SEQ = 8'b1000_1101; // bit k = k-th output: 1,0,1,1,0,0,0,1

    initial begin
        exp_t e;
        logic [7:0] seq;
        seq = CH37_SEQ;
        rst = 1'b1;
        bus.data_in = 1'b0;
        bus.data_in_valid = 1'b0;
        bus.data_in_valid_first = 1'b0;
        bus.channel_number = '0;
        bus.channel_number_load = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_data_out", 32'(bus.data_out), 32'd0);
        chk("reset_data_out_valid", 32'(bus.data_out_valid), 32'd0);
        chk("reset_last", 32'(bus.data_out_valid_last), 32'd0);
        chk("reset_payload_length", 32'(bus.payload_length), 32'd0);
        chk("reset_plv", 32'(bus.payload_length_valid), 32'd0);
        chk("reset_length_error", 32'(bus.length_error), 32'd0);

        // first-without-valid and valid-without-first in IDLE are both ignored
        send_bit(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, '0, 0);
        send_ignored(3);

        // Channel 37, zero input bits, one bit per 16 cycles
        send_bit(1'b0, 1'b0, 1'b0, 1'b1, 6'd37, 1'b0, '0, 0);
        for (int i = 0; i < 8; i++) begin
            e = '0;
            e.d = seq[i];
            send_bit(1'b0, i == 0, 1'b1, 1'b0, 6'd0, 1'b1, e, 15);
        end

        // Round trip channel 12, length 6 (its first bit aborts the channel-37 stream)
        send_bit(1'b0, 1'b0, 1'b0, 1'b1, 6'd12, 1'b0, '0, 0);
        run_pdu(6'd12, 8'h02, 8'd6, 0, -1, 6'd0);
        // Zero-length PDU: header + CRC only
        run_pdu(6'd12, 8'h03, 8'd0, 0, -1, 6'd0);
        // Length 38 > 37: error at bit 16, trailing bits ignored
        run_pdu(6'd12, 8'h01, 8'd38, 0, -1, 6'd0);
        send_ignored(10);
        // Abort at bit 30 by a new first bit, then a clean PDU
        run_pdu(6'd12, 8'h11, 8'd10, 30, -1, 6'd0);
        run_pdu(6'd12, 8'h22, 8'd2, 0, -1, 6'd0);

        // Seed 5, reload to 20 mid-PDU, then a load coinciding with the next start
        send_bit(1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0, '0, 0);
        run_pdu(6'd5, 8'h04, 8'd4, 0, 20, 6'd20);
        run_pdu(6'd20, 8'h05, 8'd1, 0, 0, 6'd33);

        // Reset at bit 50 of a seed-33 PDU
        run_pdu(6'd33, 8'h06, 8'd10, 50, -1, 6'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_data_out_valid", 32'(bus.data_out_valid), 32'd0);
        chk("midrst_last", 32'(bus.data_out_valid_last), 32'd0);
        chk("midrst_payload_length", 32'(bus.payload_length), 32'd0);
        send_ignored(5);
        // Seed register was cleared by reset
        run_pdu(6'd0, 8'h07, 8'd0, 0, -1, 6'd0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
